rect_renderer: RTL and testbench
================================

# rect_renderer

Parametrised rectangle rasteriser, the successor to the fixed square walker. On a start request it latches an origin, width and height, then emits one pixel coordinate per accepted transfer in raster order (left to right, then top to bottom) over a valid/ready stream. It sits between the shape command decoder and the framebuffer write arbiter, and may optionally emit only the outline.

## Interface
- X_W, 10: x coordinate width.
- Y_W, 9: y coordinate width.
- DIM_W, 8: width/height field width.
- clock  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- origin_x  in  X_W  top-left x.
- origin_y  in  Y_W  top-left y.
- width  in  DIM_W  pixels per row; 0 means empty.
- height  in  DIM_W  rows; 0 means empty.
- outline  in  1  present only with RECT_OUTLINE_EN; 1 selects border-only.
- out_x  out  X_W  pixel x.
- out_y  out  Y_W  pixel y.
- out_valid  out  1  out_x/out_y hold a pixel.
- out_ready  in  1  downstream accepts the pixel when high with out_valid.
- busy  out  1  high in DRAW and DONE.
- done  out  1  one-cycle pulse when the rectangle completes.

## Operation
- States: IDLE, DRAW, DONE.
- IDLE with start=1 and width≠0 and height≠0:
  - Latch origin, width, height and outline.
  - Load the x/y counters to the origin.
  - Go to DRAW.
- IDLE with start=1 and a zero dimension: go straight to DONE. No pixels are emitted.
- DRAW: out_valid=1 and out_x/out_y come from registers. On valid&&ready, advance to the next pixel:
  - Not at row end: x+1.
  - At row end, not the last row: x reloads to origin_x, y+1.
  - Last pixel of the last row: go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored outside IDLE. Live input changes after latching have no effect.
- Arithmetic: column/row offset counters are DIM_W wide. Output coordinates are origin plus offset, truncated to X_W/Y_W, so coordinates wrap modulo 2^X_W / 2^Y_W. There is no clipping.
- Without backpressure the pixel order and count are exactly width×height.

## Timing
- Reset values: state IDLE; out_valid=0, busy=0, done=0, out_x=0, out_y=0.
- Latency: start in cycle N puts the first pixel valid in cycle N+1.
- With out_ready held high, one pixel is emitted per cycle. done is asserted in the cycle after the last accepted pixel.
- out_valid, once asserted, stays high and out_x/out_y stay stable until accepted.
- Zero-dimension request: done in cycle N+1, busy high in cycle N+1 only.
- start in the same cycle as done (DONE state) is ignored. A new request is accepted in the following IDLE cycle.
- resetn low at any time, including mid-row with a pixel pending: the block returns immediately to the reset values. The pending pixel is dropped.

## Configuration
- RECT_OUTLINE_EN defined:
  - The outline port exists.
  - With outline=1, interior rows emit only the first and last column: x jumps from origin_x to origin_x+width-1.
  - Rows 0 and height-1 are emitted in full.
  - width=1 or height=1 degenerates to the filled result with no duplicate pixels.
- RECT_OUTLINE_EN undefined: the outline port is absent and every rectangle is filled.

## Structure
- render_pkg holds the state enum (IDLE/DRAW/DONE) and the default X_W/Y_W/DIM_W constants shared with other renderers.
- One sub-module, span_counter: a DIM_W offset counter with load, advance and an at_end flag. It is instantiated once for columns and once for rows. The outline skip logic stays in rect_renderer.

## Test plan
- Fill 3×2 at (10,20), out_ready=1: pixels (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) in cycles N+1..N+6; done in N+7.
- Same request with out_ready toggling 1,0 each cycle: the same six pixels in the same order, each held stable while stalled; done the cycle after the sixth acceptance.
- width=0, height=5: out_valid never asserts; done pulses in cycle N+1.
- RECT_OUTLINE_EN, outline=1, 4×4 at (0,0): exactly 12 pixels; row 1 gives (0,1),(3,1); no (1,1),(2,2).
- Origin (1022,510), 4×4 with X_W=10, Y_W=9: x sequence 1022,1023,0,1; y wraps 510,511,0,1.
- resetn pulled low after the third pixel of a 5×5, then start issued again: all outputs zero during reset; the restarted rectangle begins at the origin and emits 25 pixels.

Source files
------------

// File: rtl/render_pkg.sv
// render_pkg
// Shared definitions for the renderer family: the walker state enum and the
// default coordinate / dimension widths used by rect_renderer and its peers.
package render_pkg;

  // Default x coordinate width (1024-wide framebuffer)
  localparam int X_W_DEF   = 10;
  // Default y coordinate width (512 rows)
  localparam int Y_W_DEF   = 9;
  // Default width/height field width
  localparam int DIM_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } render_state_t;

endpackage

// File: rtl/rect_renderer_if.sv
// rect_renderer_if
// Pixel output stream of the rectangle renderer (valid/ready).
//   out_x     : pixel x coordinate
//   out_y     : pixel y coordinate
//   out_valid : out_x/out_y hold a pixel
//   out_ready : consumer accepts the pixel when high together with out_valid
// Modports: master (renderer side), slave (framebuffer arbiter side).
interface rect_renderer_if
  import render_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF
);

  logic [X_W-1:0] out_x;
  logic [Y_W-1:0] out_y;
  logic           out_valid;
  logic           out_ready;

  modport master (output out_x, output out_y, output out_valid, input out_ready);
  modport slave  (input out_x, input out_y, input out_valid, output out_ready);

endinterface

// File: rtl/span_counter.sv
// span_counter
// DIM_W-wide offset counter used for both the column and the row walk.
//   clock, resetn : clock and asynchronous active-low reset
//   load          : offset <= load_val (takes priority over advance)
//   advance       : offset <= offset + 1
//   load_val      : value to load
//   end_val       : offset value that marks the end of the span
//   offset        : current offset
//   at_end        : offset == end_val
module span_counter #(
  parameter int DIM_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic             advance,
  input  logic [DIM_W-1:0] load_val,
  input  logic [DIM_W-1:0] end_val,
  output logic [DIM_W-1:0] offset,
  output logic             at_end
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      offset <= '0;
    end else if (load) begin
      offset <= load_val;
    end else if (advance) begin
      offset <= offset + DIM_W'(1);
    end
  end

  assign at_end = (offset == end_val);

endmodule

// File: rtl/rect_renderer.sv
// rect_renderer
// Rectangle rasteriser: latches origin/width/height on start and emits one
// pixel coordinate per accepted transfer in raster order.
//   clock, resetn  : clock and asynchronous active-low reset
//   start          : request, sampled only in IDLE
//   origin_x/y     : top-left corner
//   width/height   : rectangle size, a zero in either means empty
//   outline        : border-only select (only with RECT_OUTLINE_EN defined)
//   pix            : pixel stream (rect_renderer_if.master)
//   busy           : high in DRAW and DONE
//   done           : one-cycle pulse when the rectangle completes
// Build option: RECT_OUTLINE_EN adds the outline port and border-only mode;
// without it every rectangle is filled.
module rect_renderer
  import render_pkg::*;
#(
  parameter int X_W   = X_W_DEF,
  parameter int Y_W   = Y_W_DEF,
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [X_W-1:0]     origin_x,
  input  logic [Y_W-1:0]     origin_y,
  input  logic [DIM_W-1:0]   width,
  input  logic [DIM_W-1:0]   height,
`ifdef RECT_OUTLINE_EN
  input  logic               outline,
`endif
  rect_renderer_if.master    pix,
  output logic               busy,
  output logic               done
);

  render_state_t state_q, state_d;

  logic [X_W-1:0]   ox_q;
  logic [Y_W-1:0]   oy_q;
  logic [DIM_W-1:0] w_q, h_q;
  logic             outline_q;
  logic             latch;

  logic             col_load, col_adv, col_end;
  logic             row_load, row_adv, row_end;
  logic [DIM_W-1:0] col_val, col_off, row_off;
  logic [DIM_W-1:0] w_last, h_last;
  logic             fire;
  logic             skip_interior;

  assign w_last = w_q - DIM_W'(1);
  assign h_last = h_q - DIM_W'(1);

  span_counter #(.DIM_W(DIM_W)) u_col (
    .clock    (clock),
    .resetn   (resetn),
    .load     (col_load),
    .advance  (col_adv),
    .load_val (col_val),
    .end_val  (w_last),
    .offset   (col_off),
    .at_end   (col_end)
  );

  span_counter #(.DIM_W(DIM_W)) u_row (
    .clock    (clock),
    .resetn   (resetn),
    .load     (row_load),
    .advance  (row_adv),
    .load_val ('0),
    .end_val  (h_last),
    .offset   (row_off),
    .at_end   (row_end)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request parameters are captured once so later input changes cannot
  // disturb a rectangle in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ox_q <= '0;
      oy_q <= '0;
      w_q  <= '0;
      h_q  <= '0;
    end else if (latch) begin
      ox_q <= origin_x;
      oy_q <= origin_y;
      w_q  <= width;
      h_q  <= height;
    end
  end

`ifdef RECT_OUTLINE_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      outline_q <= 1'b0;
    end else if (latch) begin
      outline_q <= outline;
    end
  end
`else
  assign outline_q = 1'b0;
`endif

  assign fire = (state_q == DRAW) && pix.out_ready;

  // On an interior row of an outline, column 0 jumps straight to the last
  // column. Width 1/2 never reach this (column 0 is already the end, or the
  // jump equals a plain +1), so degenerate shapes emit no duplicates.
  assign skip_interior = outline_q && (col_off == '0) && (row_off != '0) && !row_end;

  always_comb begin
    state_d  = state_q;
    latch    = 1'b0;
    col_load = 1'b0;
    col_adv  = 1'b0;
    col_val  = '0;
    row_load = 1'b0;
    row_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch    = 1'b1;
          col_load = 1'b1;
          row_load = 1'b1;
          state_d  = ((width != '0) && (height != '0)) ? DRAW : DONE;
        end
      end
      DRAW: begin
        if (fire) begin
          if (col_end && row_end) begin
            state_d = DONE;
          end else if (col_end) begin
            col_load = 1'b1;
            row_adv  = 1'b1;
          end else if (skip_interior) begin
            col_load = 1'b1;
            col_val  = w_last;
          end else begin
            col_adv = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Coordinates wrap modulo 2^X_W / 2^Y_W; there is no clipping.
  assign pix.out_x     = ox_q + X_W'(col_off);
  assign pix.out_y     = oy_q + Y_W'(row_off);
  assign pix.out_valid = (state_q == DRAW);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_rect_renderer.sv
// tb_rect_renderer
// Self-checking bench for rect_renderer: table of directed requests, random
// requests against a raster-order reference model, and a mid-run reset.
// Build option: RECT_OUTLINE_EN enables border-only expectations.
module tb_rect_renderer;

`ifdef RECT_OUTLINE_EN
  localparam bit OUTLINE_EN = 1'b1;
`else
  localparam bit OUTLINE_EN = 1'b0;
`endif

  logic       clock;
  logic       resetn;
  logic       start;
  logic [9:0] origin_x;
  logic [8:0] origin_y;
  logic [7:0] width;
  logic [7:0] height;
  logic       outline;
  logic       busy;
  logic       done;

  int checkCount = 0;
  int passCount  = 0;

  rect_renderer_if #(.X_W(10), .Y_W(9)) pix ();

  rect_renderer #(.X_W(10), .Y_W(9), .DIM_W(8)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .origin_x (origin_x),
    .origin_y (origin_y),
    .width    (width),
    .height   (height),
`ifdef RECT_OUTLINE_EN
    .outline  (outline),
`endif
    .pix      (pix),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [9:0] ox;
    logic [8:0] oy;
    logic [7:0] w;
    logic [7:0] h;
    logic       ol;
    int         mode;
    int         exp_count;
    bit         start_in_done;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one request and follows it to completion. mode: 0 ready high,
  // 1 ready toggling 1,0, 2 random ready. exp_count < 0 skips the table count.
  task automatic applyStimulus(input logic [9:0] ox, input logic [8:0] oy,
                               input logic [7:0] w, input logic [7:0] h,
                               input logic ol, input int mode, input int exp_count,
                               input bit start_in_done);
    logic [9:0] qx[$];
    logic [8:0] qy[$];
    logic [9:0] hx;
    logic [8:0] hy;
    logic [9:0] ex;
    logic [8:0] ey;
    bit   eff_ol, held, toggle, rdy;
    int   model_n, got, last_acc, done_cyc, budget;

    @(negedge clock);
    origin_x = ox;
    origin_y = oy;
    width    = w;
    height   = h;
    outline  = ol;
    start    = 1'b1;
    pix.out_ready = 1'b1;

    // Reference: every (col,row) of the rectangle in raster order, dropping
    // interior cells when the outline is in effect, coordinates modulo size.
    eff_ol = OUTLINE_EN && outline;
    for (int r = 0; r < int'(h); r++) begin
      for (int c = 0; c < int'(w); c++) begin
        if (!eff_ol || r == 0 || r == int'(h) - 1 || c == 0 || c == int'(w) - 1) begin
          qx.push_back(10'((int'(ox) + c) % 1024));
          qy.push_back(9'((int'(oy) + r) % 512));
        end
      end
    end
    model_n  = qx.size();
    got      = 0;
    last_acc = 0;
    done_cyc = 0;
    held     = 1'b0;
    toggle   = 1'b1;
    budget   = model_n * 4 + 20;

    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clock);
      if (cyc == 1) begin
        start    = 1'b0;
        origin_x = 10'($urandom);
        origin_y = 9'($urandom);
        width    = 8'($urandom);
        height   = 8'($urandom);
        outline  = 1'($urandom);
        checkOutput("busy_after_start", busy, 1);
        if (model_n > 0) checkOutput("first_pixel_latency", pix.out_valid, 1);
      end
      if (done) begin
        done_cyc = cyc;
        checkOutput("valid_in_done", pix.out_valid, 0);
        checkOutput("busy_in_done", busy, 1);
        break;
      end
      if (cyc == 2) begin
        start  = 1'b1;
        width  = 8'd9;
        height = 8'd9;
      end else if (cyc == 3) begin
        start = 1'b0;
      end
      if (pix.out_valid) begin
        checkOutput("busy_in_draw", busy, 1);
        if (held) begin
          checkOutput("stall_x_stable", pix.out_x, hx);
          checkOutput("stall_y_stable", pix.out_y, hy);
        end
        if (mode == 0) begin
          rdy = 1'b1;
        end else if (mode == 1) begin
          rdy = toggle;
          toggle = ~toggle;
        end else begin
          rdy = 1'($urandom);
        end
        pix.out_ready = rdy;
        if (rdy) begin
          checkOutput("no_extra_pixel", (got < model_n) ? 1 : 0, 1);
          if (got < model_n) begin
            ex = qx.pop_front();
            ey = qy.pop_front();
            checkOutput("pixel_x", pix.out_x, ex);
            checkOutput("pixel_y", pix.out_y, ey);
          end
          got++;
          last_acc = cyc;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hx = pix.out_x;
          hy = pix.out_y;
        end
      end else begin
        checkOutput("valid_or_done", 0, 1);
      end
    end

    start = start_in_done ? 1'b1 : 1'b0;
    width = 8'd3;
    height = 8'd3;
    checkOutput("completed_in_budget", (done_cyc != 0) ? 1 : 0, 1);
    if (done_cyc != 0) begin
      checkOutput("done_timing", done_cyc, (model_n == 0) ? 1 : last_acc + 1);
    end
    checkOutput("pixel_count_model", got, model_n);
    if (exp_count >= 0) checkOutput("pixel_count_table", got, exp_count);

    @(negedge clock);
    start = 1'b0;
    checkOutput("done_one_cycle", done, 0);
    checkOutput("idle_after_done", busy, 0);
    checkOutput("idle_no_valid", pix.out_valid, 0);
  endtask

  initial begin
    int acc;

    vecs[0]  = '{10'd10,   9'd20,  8'd3,   8'd2, 1'b0, 0, 6, 1'b0};
    vecs[1]  = '{10'd10,   9'd20,  8'd3,   8'd2, 1'b0, 1, 6, 1'b1};
    vecs[2]  = '{10'd7,    9'd7,   8'd0,   8'd5, 1'b0, 0, 0, 1'b0};
    vecs[3]  = '{10'd7,    9'd7,   8'd5,   8'd0, 1'b0, 0, 0, 1'b1};
    vecs[4]  = '{10'd1022, 9'd510, 8'd4,   8'd4, 1'b0, 0, 16, 1'b0};
    vecs[5]  = '{10'd0,    9'd0,   8'd4,   8'd4, 1'b1, 0, OUTLINE_EN ? 12 : 16, 1'b0};
    vecs[6]  = '{10'd100,  9'd50,  8'd1,   8'd1, 1'b0, 1, 1, 1'b0};
    vecs[7]  = '{10'd5,    9'd5,   8'd1,   8'd4, 1'b1, 0, 4, 1'b0};
    vecs[8]  = '{10'd5,    9'd5,   8'd4,   8'd1, 1'b1, 2, 4, 1'b0};
    vecs[9]  = '{10'd3,    9'd3,   8'd2,   8'd3, 1'b1, 2, 6, 1'b0};
    vecs[10] = '{10'd1000, 9'd500, 8'd255, 8'd2, 1'b0, 0, 510, 1'b0};

    resetn   = 1'b0;
    start    = 1'b0;
    origin_x = '0;
    origin_y = '0;
    width    = '0;
    height   = '0;
    outline  = 1'b0;
    pix.out_ready = 1'b0;
    #2;
    checkOutput("reset_valid", pix.out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_x", pix.out_x, 0);
    checkOutput("reset_y", pix.out_y, 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].ox, vecs[i].oy, vecs[i].w, vecs[i].h, vecs[i].ol,
                    vecs[i].mode, vecs[i].exp_count, vecs[i].start_in_done);
    end

    for (int i = 0; i < 20; i++) begin
      applyStimulus(10'($urandom), 9'($urandom), 8'($urandom_range(0, 6)),
                    8'($urandom_range(0, 6)), 1'($urandom), 2, -1, 1'($urandom));
    end

    // Reset with the fourth pixel of a 5x5 pending, then restart.
    @(negedge clock);
    origin_x = 10'd30;
    origin_y = 9'd40;
    width    = 8'd5;
    height   = 8'd5;
    outline  = 1'b0;
    start    = 1'b1;
    pix.out_ready = 1'b1;
    acc = 0;
    for (int cyc = 0; cyc < 20 && acc < 3; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (pix.out_valid) acc++;
    end
    checkOutput("pre_reset_accepts", acc, 3);
    @(negedge clock);
    checkOutput("pre_reset_pending", pix.out_valid, 1);
    checkOutput("pre_reset_x", pix.out_x, 33);
    resetn = 1'b0;
    #1;
    checkOutput("midrun_reset_valid", pix.out_valid, 0);
    checkOutput("midrun_reset_busy", busy, 0);
    checkOutput("midrun_reset_done", done, 0);
    checkOutput("midrun_reset_x", pix.out_x, 0);
    checkOutput("midrun_reset_y", pix.out_y, 0);
    @(negedge clock);
    checkOutput("held_reset_valid", pix.out_valid, 0);
    resetn = 1'b1;
    applyStimulus(10'd30, 9'd40, 8'd5, 8'd5, 1'b0, 0, 25, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
